// File: rtl/pad_pkg.sv
// pad_pkg: shared types and defaults for pad input conditioning blocks.
package pad_pkg;
    typedef enum logic {IDLE, WAIT} deb_state_t;
    localparam int DEB_CYCLES_DEFAULT = 16;
endpackage

// File: rtl/pad_debounce_if.sv
// pad_debounce_if: pad level/qualifier in, debounced level and edge strobes out.
interface pad_debounce_if;
    logic IN0;
    logic SAMPLE_EN;
    logic Y;
    logic RISE;
    logic FALL;
    logic BUSY;
    modport master (output IN0, SAMPLE_EN, input Y, RISE, FALL, BUSY);
    modport slave (input IN0, SAMPLE_EN, output Y, RISE, FALL, BUSY);
endinterface

// File: rtl/sync2.sv
// sync2: two-flop synchronizer bringing an asynchronous level into the CLK domain.
module sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic D,
    output logic Q
);
    logic s1_q, s2_q;
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1_q <= RST_VAL;
            s2_q <= RST_VAL;
        end else begin
            s1_q <= D;
            s2_q <= s1_q;
        end
    end
    assign Q = s2_q;
endmodule

// File: rtl/pad_debounce.sv
// pad_debounce: synchronizes a schmitt pad level and accepts a new level only after
// DEB_CYCLES consecutive qualified samples, emitting one-cycle RISE/FALL strobes.
module pad_debounce
    import pad_pkg::*;
#(
    parameter int   DEB_CYCLES = DEB_CYCLES_DEFAULT,
    parameter int   CNT_W      = $clog2(DEB_CYCLES),
    parameter logic RST_VAL    = 1'b0
) (
    input  logic CLK,
    input  logic RST_N,
    pad_debounce_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);
    deb_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             y_q, y_d, rise_q, rise_d, fall_q, fall_d;
    logic             s2;
    sync2 #(.RST_VAL(RST_VAL)) u_sync (
        .CLK  (CLK),
        .RST_N(RST_N),
        .D    (bus.IN0),
        .Q    (s2)
    );
    // A matching sample aborts regardless of SAMPLE_EN, so abort outranks commit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (state_q == IDLE) begin
            state_d = (bus.SAMPLE_EN && s2 != y_q) ? WAIT : IDLE;
            cnt_d   = (bus.SAMPLE_EN && s2 != y_q) ? CNT_W'(1) : '0;
        end else if (s2 == y_q) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (bus.SAMPLE_EN && cnt_q == CNT_MAX) begin
            state_d = IDLE;
            cnt_d   = '0;
            y_d     = ~y_q;
            rise_d  = ~y_q;
            fall_d  = y_q;
        end else if (bus.SAMPLE_EN) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            y_q     <= RST_VAL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end
    assign bus.Y    = y_q;
    assign bus.RISE = rise_q;
    assign bus.FALL = fall_q;
    assign bus.BUSY = (state_q == WAIT);
endmodule
